// File: rtl/mtr_sched_pkg.sv
// Shared widths, channel state encoding and the saturating ramp step
// for the motor duty scheduler.
package mtr_sched_pkg;

  localparam int              DUTY_W   = 11;
  localparam int              SPD_W    = 12;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BRAKE = 2'd1,
    DEAD  = 2'd2
  } chan_state_t;

  // One rate-limited move of cur toward tgt; 12-bit math so nothing wraps.
  function automatic logic [DUTY_W-1:0] ramp(
    input logic [DUTY_W-1:0] cur,
    input logic [SPD_W-1:0]  tgt,
    input logic [SPD_W-1:0]  step
  );
    logic [SPD_W-1:0] c;
    logic [SPD_W-1:0] nxt;
    c = {1'b0, cur};
    if (tgt > c) begin
      nxt = c + step;
      if (nxt > tgt) begin
        nxt = tgt;
      end
    end else begin
      nxt = (c > step) ? (c - step) : {SPD_W{1'b0}};
      if (nxt < tgt) begin
        nxt = tgt;
      end
    end
    return DUTY_W'(nxt);
  endfunction

endpackage

// File: rtl/mtr_chan_seq.sv
// One motor channel: speed-to-magnitude conversion, ramp limiter and the
// RUN/BRAKE/DEAD reversal sequencer, updated only on PWM period boundaries.
module mtr_chan_seq
  import mtr_sched_pkg::*;
#(
  parameter int STEP     = 64,
  parameter int DEAD_PER = 2,
  parameter int MIN_DUTY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    bnd,
  input  logic signed [SPD_W-1:0] spd,
  output logic [DUTY_W-1:0]       duty,
  output logic                    rev
);

  localparam int                DCNT_W    = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
  localparam int                SUM_W     = SPD_W + 1;
  localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(DEAD_PER - 1);
  localparam logic [SPD_W-1:0]  STEP_V    = SPD_W'(STEP);
  localparam logic [SUM_W-1:0]  MIN_V     = SUM_W'(MIN_DUTY);
  localparam logic [SPD_W-1:0]  SPD_MIN   = {1'b1, {(SPD_W-1){1'b0}}};

  chan_state_t       state_r;
  logic [DCNT_W-1:0] dcnt_r;
  logic [DUTY_W-1:0] duty_r;
  logic              rev_r;

  logic              req_rev_s;
  logic              nz_s;
  logic              opp_s;
  logic [SPD_W-1:0]  mag_s;
  logic [SPD_W-1:0]  tgt_s;
  logic [SUM_W-1:0]  sum_s;
  logic [DUTY_W-1:0] up_s;
  logic [DUTY_W-1:0] dn_s;
  logic [DUTY_W-1:0] first_s;

  // Target magnitude, direction request and candidate next duties.
  always_comb begin
    req_rev_s = spd[SPD_W-1];
    nz_s      = (spd != {SPD_W{1'b0}});
    if (spd == SPD_MIN) begin
      mag_s = {1'b0, DUTY_MAX};
    end else if (req_rev_s) begin
      mag_s = $unsigned(-spd);
    end else begin
      mag_s = $unsigned(spd);
    end
    sum_s = {1'b0, mag_s} + MIN_V;
    if (!nz_s) begin
      tgt_s = {SPD_W{1'b0}};
    end else if (sum_s > {2'b00, DUTY_MAX}) begin
      tgt_s = {1'b0, DUTY_MAX};
    end else begin
      tgt_s = sum_s[SPD_W-1:0];
    end
    opp_s   = nz_s && (req_rev_s != rev_r);
    up_s    = ramp(duty_r, tgt_s, STEP_V);
    dn_s    = ramp(duty_r, {SPD_W{1'b0}}, STEP_V);
    first_s = (tgt_s < STEP_V) ? DUTY_W'(tgt_s) : DUTY_W'(STEP_V);
  end

  // Channel sequencer; disable overrides the boundary alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      dcnt_r  <= {DCNT_W{1'b0}};
      duty_r  <= {DUTY_W{1'b0}};
      rev_r   <= 1'b0;
    end else if (!en) begin
      state_r <= RUN;
      dcnt_r  <= {DCNT_W{1'b0}};
      duty_r  <= {DUTY_W{1'b0}};
    end else if (bnd) begin
      case (state_r)
        RUN: begin
          if (opp_s && (duty_r != {DUTY_W{1'b0}})) begin
            state_r <= BRAKE;
            duty_r  <= dn_s;
          end else if (opp_s) begin
            state_r <= DEAD;
            dcnt_r  <= DCNT_INIT;
          end else begin
            duty_r  <= up_s;
          end
        end
        BRAKE: begin
          if (!opp_s) begin
            state_r <= RUN;
            duty_r  <= up_s;
          end else begin
            duty_r <= dn_s;
            if (dn_s == {DUTY_W{1'b0}}) begin
              state_r <= DEAD;
              dcnt_r  <= DCNT_INIT;
            end
          end
        end
        DEAD: begin
          if (dcnt_r != {DCNT_W{1'b0}}) begin
            dcnt_r <= dcnt_r - DCNT_W'(1);
            duty_r <= {DUTY_W{1'b0}};
          end else begin
            state_r <= RUN;
            duty_r  <= first_s;
            if (opp_s) begin
              rev_r <= ~rev_r;
            end
          end
        end
        default: begin
          state_r <= RUN;
          dcnt_r  <= {DCNT_W{1'b0}};
          duty_r  <= {DUTY_W{1'b0}};
        end
      endcase
    end
  end

  assign duty = duty_r;
  assign rev  = rev_r;

endmodule

// File: rtl/mtr_duty_sched.sv
// Duty scheduler top: free-running PWM period counter in lockstep with the
// PWM11 instances, plus one sequencer per wheel.
module mtr_duty_sched
  import mtr_sched_pkg::*;
#(
  parameter int STEP     = 64,
  parameter int DEAD_PER = 2,
  parameter int MIN_DUTY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [SPD_W-1:0] lft_spd,
  input  logic signed [SPD_W-1:0] rght_spd,
  output logic [DUTY_W-1:0]       lft_duty,
  output logic [DUTY_W-1:0]       rght_duty,
  output logic                    lft_rev,
  output logic                    rght_rev,
  output logic                    bnd
);

  logic [DUTY_W-1:0] pcnt_r;
  logic              bnd_r;

  // Period counter; bnd is registered one count early so it is high at 0x7FF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r <= {DUTY_W{1'b0}};
      bnd_r  <= 1'b0;
    end else begin
      pcnt_r <= pcnt_r + DUTY_W'(1);
      bnd_r  <= (pcnt_r == (DUTY_MAX - DUTY_W'(1)));
    end
  end

  assign bnd = bnd_r;

  mtr_chan_seq #(
    .STEP     (STEP),
    .DEAD_PER (DEAD_PER),
    .MIN_DUTY (MIN_DUTY)
  ) u_lft (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bnd   (bnd_r),
    .spd   (lft_spd),
    .duty  (lft_duty),
    .rev   (lft_rev)
  );

  mtr_chan_seq #(
    .STEP     (STEP),
    .DEAD_PER (DEAD_PER),
    .MIN_DUTY (MIN_DUTY)
  ) u_rght (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bnd   (bnd_r),
    .spd   (rght_spd),
    .duty  (rght_duty),
    .rev   (rght_rev)
  );

endmodule
